// File: rtl/axi4_scratch_responder.sv
// axi4_scratch_responder
//   AXI4 subordinate in front of a word-addressed scratchpad. The read and
//   write paths are independent, with one transaction outstanding per
//   direction. Supports FIXED/INCR bursts and byte strobes, and returns
//   OKAY / SLVERR / DECERR, with the worst response held for the whole burst.
//   The array has one write port and one read port. A read and a write to the
//   same word in the same cycle returns the old data.
// Ports
//   clock, reset             : rising-edge clock, async active-low reset
//   io_s_axi_aw_* / w_* / b_ : write address, data and response channels
//   io_s_axi_ar_* / r_*      : read address and data channels
// Optional build macro
//   AXI_SCRATCH_ZERO_INIT_EN : after reset, sweep zeros through the array,
//                              one word per cycle, before either port opens.
module axi4_scratch_responder #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_s_axi_aw_valid,
  output logic                    io_s_axi_aw_ready,
  input  logic [ID_WIDTH-1:0]     io_s_axi_aw_bits_id,
  input  logic [ADDR_WIDTH-1:0]   io_s_axi_aw_bits_addr,
  input  logic [7:0]              io_s_axi_aw_bits_len,
  input  logic [2:0]              io_s_axi_aw_bits_size,
  input  logic [1:0]              io_s_axi_aw_bits_burst,
  input  logic                    io_s_axi_w_valid,
  output logic                    io_s_axi_w_ready,
  input  logic [DATA_WIDTH-1:0]   io_s_axi_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0] io_s_axi_w_bits_strb,
  input  logic                    io_s_axi_w_bits_last,
  output logic                    io_s_axi_b_valid,
  input  logic                    io_s_axi_b_ready,
  output logic [ID_WIDTH-1:0]     io_s_axi_b_bits_id,
  output logic [1:0]              io_s_axi_b_bits_resp,
  input  logic                    io_s_axi_ar_valid,
  output logic                    io_s_axi_ar_ready,
  input  logic [ID_WIDTH-1:0]     io_s_axi_ar_bits_id,
  input  logic [ADDR_WIDTH-1:0]   io_s_axi_ar_bits_addr,
  input  logic [7:0]              io_s_axi_ar_bits_len,
  input  logic [2:0]              io_s_axi_ar_bits_size,
  input  logic [1:0]              io_s_axi_ar_bits_burst,
  output logic                    io_s_axi_r_valid,
  input  logic                    io_s_axi_r_ready,
  output logic [ID_WIDTH-1:0]     io_s_axi_r_bits_id,
  output logic [DATA_WIDTH-1:0]   io_s_axi_r_bits_data,
  output logic [1:0]              io_s_axi_r_bits_resp,
  output logic                    io_s_axi_r_bits_last
);
  localparam int unsigned STRB_W     = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);
  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN64     = 64'(DEPTH) * 64'(STRB_W);
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_INIT} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_INIT} r_state_e;

  // Byte offset from BASE_ADDR; the extra MSB catches addresses below base.
  function automatic logic [ADDR_WIDTH:0] off_of(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDR};
  endfunction
  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(off_of(a) >> BYTE_SHIFT);
  endfunction
  // Bad burst type (WRAP/reserved) or a beat wider than the bus.
  function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size > 3'(BYTE_SHIFT));
  endfunction
  function automatic logic [1:0] beat_resp(input logic bad, input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = off_of(a);
    if (bad) return SLVERR;
    if (off[ADDR_WIDTH] || (64'(off) >= SPAN64)) return DECERR;
    return OKAY;
  endfunction
  // The encodings order by severity, so the numerically larger code wins.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic                  w_incr_q, w_incr_d, w_bad_q, w_bad_d;
  logic [1:0]            b_resp_q, b_resp_d, w_beat;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next_addr;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic                  r_incr_q, r_incr_d, r_bad_q, r_bad_d;
  logic                  r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [1:0]            r_resp_q, r_resp_d, r_beat;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d, rd_word;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [STRB_W-1:0]     mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef AXI_SCRATCH_ZERO_INIT_EN
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic             init_last;
  assign init_last = (w_state_q == W_INIT) && (init_cnt_q == IDX_W'(DEPTH - 1));
  localparam w_state_e W_RST = W_INIT;
  localparam r_state_e R_RST = R_INIT;
`else
  localparam w_state_e W_RST = W_IDLE;
  localparam r_state_e R_RST = R_IDLE;
`endif

  // ---------------- write path ----------------
  always_comb begin
    w_state_d = w_state_q;
    aw_id_d   = aw_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_incr_d  = w_incr_q;
    w_bad_d   = w_bad_q;
    w_cnt_d   = w_cnt_q;
    b_resp_d  = b_resp_q;
    w_beat    = beat_resp(w_bad_q, w_addr_q);
    mem_we    = 1'b0;
    mem_idx   = idx_of(w_addr_q);
    mem_be    = io_s_axi_w_bits_strb;
    mem_wdata = io_s_axi_w_bits_data;
`ifdef AXI_SCRATCH_ZERO_INIT_EN
    init_cnt_d = init_cnt_q;
`endif
    unique case (w_state_q)
      W_IDLE: if (io_s_axi_aw_valid) begin
        aw_id_d   = io_s_axi_aw_bits_id;
        w_addr_d  = io_s_axi_aw_bits_addr;
        w_len_d   = io_s_axi_aw_bits_len;
        w_size_d  = io_s_axi_aw_bits_size;
        w_incr_d  = (io_s_axi_aw_bits_burst == 2'b01);
        w_bad_d   = bad_req(io_s_axi_aw_bits_burst, io_s_axi_aw_bits_size);
        w_cnt_d   = '0;
        b_resp_d  = OKAY;
        w_state_d = W_DATA;
      end
      W_DATA: if (io_s_axi_w_valid) begin
        mem_we = (w_beat == OKAY);
        // A misplaced or missing w_last is an error but does not end the burst.
        if (io_s_axi_w_bits_last != (w_cnt_q == w_len_q)) w_beat = worst(w_beat, SLVERR);
        b_resp_d = worst(b_resp_q, w_beat);
        if (w_incr_q) w_addr_d = w_addr_q + (ADDR_WIDTH'(1) << w_size_q);
        if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        else                    w_cnt_d   = w_cnt_q + 8'd1;
      end
      W_RESP: if (io_s_axi_b_ready) w_state_d = W_IDLE;
`ifdef AXI_SCRATCH_ZERO_INIT_EN
      W_INIT: begin
        mem_we     = 1'b1;
        mem_idx    = init_cnt_q;
        mem_be     = '1;
        mem_wdata  = '0;
        init_cnt_d = init_cnt_q + IDX_W'(1);
        if (init_last) w_state_d = W_IDLE;
      end
`endif
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------- read path ----------------
  // One array read per cycle: the first beat's address comes straight from AR,
  // later beats from the beat address that follows the current one.
  always_comb begin
    r_next_addr = r_addr_q + (r_incr_q ? (ADDR_WIDTH'(1) << r_size_q) : '0);
    rd_word     = mem_q[idx_of((r_state_q == R_IDLE) ? io_s_axi_ar_bits_addr : r_next_addr)];
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_incr_d  = r_incr_q;
    r_bad_d   = r_bad_q;
    r_cnt_d   = r_cnt_q;
    r_valid_d = r_valid_q;
    r_last_d  = r_last_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;
    r_beat    = OKAY;
    unique case (r_state_q)
      R_IDLE: if (io_s_axi_ar_valid) begin
        r_id_d    = io_s_axi_ar_bits_id;
        r_addr_d  = io_s_axi_ar_bits_addr;
        r_len_d   = io_s_axi_ar_bits_len;
        r_size_d  = io_s_axi_ar_bits_size;
        r_incr_d  = (io_s_axi_ar_bits_burst == 2'b01);
        r_bad_d   = bad_req(io_s_axi_ar_bits_burst, io_s_axi_ar_bits_size);
        r_beat    = beat_resp(r_bad_d, io_s_axi_ar_bits_addr);
        r_cnt_d   = '0;
        r_valid_d = 1'b1;
        r_last_d  = (io_s_axi_ar_bits_len == 8'd0);
        r_resp_d  = r_beat;
        r_data_d  = (r_beat == OKAY) ? rd_word : '0;
        r_state_d = R_DATA;
      end
      R_DATA: if (io_s_axi_r_ready) begin
        if (r_last_q) begin
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          r_beat   = beat_resp(r_bad_q, r_next_addr);
          r_addr_d = r_next_addr;
          r_cnt_d  = r_cnt_q + 8'd1;
          r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
          r_resp_d = worst(r_resp_q, r_beat);
          r_data_d = (r_beat == OKAY) ? rd_word : '0;
        end
      end
`ifdef AXI_SCRATCH_ZERO_INIT_EN
      R_INIT: if (init_last) r_state_d = R_IDLE;
`endif
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_RST;
      aw_id_q   <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_incr_q  <= 1'b0;
      w_bad_q   <= 1'b0;
      w_cnt_q   <= '0;
      b_resp_q  <= OKAY;
      r_state_q <= R_RST;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_incr_q  <= 1'b0;
      r_bad_q   <= 1'b0;
      r_cnt_q   <= '0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_resp_q  <= OKAY;
      r_data_q  <= '0;
`ifdef AXI_SCRATCH_ZERO_INIT_EN
      init_cnt_q <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      aw_id_q   <= aw_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_incr_q  <= w_incr_d;
      w_bad_q   <= w_bad_d;
      w_cnt_q   <= w_cnt_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_incr_q  <= r_incr_d;
      r_bad_q   <= r_bad_d;
      r_cnt_q   <= r_cnt_d;
      r_valid_q <= r_valid_d;
      r_last_q  <= r_last_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
`ifdef AXI_SCRATCH_ZERO_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
    end
  end

  // The array is not reset.
  always_ff @(posedge clock) begin
    if (mem_we)
      for (int b = 0; b < STRB_W; b++)
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  assign io_s_axi_aw_ready    = (w_state_q == W_IDLE);
  assign io_s_axi_w_ready     = (w_state_q == W_DATA);
  assign io_s_axi_b_valid     = (w_state_q == W_RESP);
  assign io_s_axi_b_bits_id   = aw_id_q;
  assign io_s_axi_b_bits_resp = b_resp_q;
  assign io_s_axi_ar_ready    = (r_state_q == R_IDLE);
  assign io_s_axi_r_valid     = r_valid_q;
  assign io_s_axi_r_bits_id   = r_id_q;
  assign io_s_axi_r_bits_data = r_data_q;
  assign io_s_axi_r_bits_resp = r_resp_q;
  assign io_s_axi_r_bits_last = r_last_q;
endmodule
